// File: rtl/sgf_round_norm.sv
// sgf_round_norm: normalize-and-round stage behind the significand multiplier.
// Takes the 2*SW-bit raw product, reduces it to SW bits with the hidden bit at
// the MSB, applies the selected IEEE-754 rounding mode and reports the exponent
// increment plus inexact/zero status under a start/done/ack handshake.
module sgf_round_norm #(
  parameter int SW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            ack_i,
  input  logic [2*SW-1:0] product_i,
  input  logic            sign_i,
  input  logic [1:0]      r_mode_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [SW-1:0]   sgf_o,
  output logic [1:0]      exp_adj_o,
  output logic            inexact_o,
  output logic            zero_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [1:0] RM_RNE  = 2'b00;
  localparam logic [1:0] RM_RZ   = 2'b01;
  localparam logic [1:0] RM_PINF = 2'b10;
  localparam logic [1:0] RM_NINF = 2'b11;

  state_t          r_state;

  // Operands captured in IDLE
  logic [2*SW-1:0] r_prod;
  logic            r_sign;
  logic [1:0]      r_mode;

  // Normalization outcome captured in NORM
  logic [SW-1:0]   r_m;
  logic            r_g;
  logic            r_s;
  logic            r_e;
  logic            r_z;

  // Result registers, only updated on the ROUND->DONE edge
  logic [SW-1:0]   r_sgf;
  logic [1:0]      r_exp_adj;
  logic            r_inexact;
  logic            r_zero;

  logic [SW-1:0]   w_m;
  logic            w_g;
  logic            w_s;
  logic            w_e;
  logic            w_z;
  logic            w_u;
  logic [SW:0]     w_r;
  logic [SW-1:0]   w_sgf;
  logic [1:0]      w_exp_adj;
  logic            w_inexact;

  // Normalize: pick the SW-bit window under the leading one and split the rest into guard and sticky
  always_comb begin
    w_m = '0;
    w_g = 1'b0;
    w_s = 1'b0;
    w_e = 1'b0;
    if (r_prod[2*SW-1]) begin
      w_m = r_prod[2*SW-1:SW];
      w_g = r_prod[SW-1];
      w_s = |r_prod[SW-2:0];
      w_e = 1'b1;
    end else begin
      w_m = r_prod[2*SW-2:SW-1];
      w_g = r_prod[SW-2];
      w_s = |r_prod[SW-3:0];
      w_e = 1'b0;
    end
    w_z = (r_prod == '0);
  end

  // Round: decide the increment, add it one bit wider and fold a carry-out back into the exponent
  always_comb begin
    w_u = 1'b0;
    case (r_mode)
      RM_RNE:  w_u = r_g & (r_s | r_m[0]);
      RM_RZ:   w_u = 1'b0;
      RM_PINF: w_u = ~r_sign & (r_g | r_s);
      RM_NINF: w_u = r_sign & (r_g | r_s);
      default: w_u = 1'b0;
    endcase
    w_r       = {1'b0, r_m} + {{SW{1'b0}}, w_u};
    w_inexact = r_g | r_s;
    if (w_r[SW]) begin
      w_sgf     = {1'b1, {(SW-1){1'b0}}};
      w_exp_adj = {1'b0, r_e} + 2'd1;
    end else begin
      w_sgf     = w_r[SW-1:0];
      w_exp_adj = {1'b0, r_e};
    end
    if (r_z) begin
      w_sgf     = '0;
      w_exp_adj = 2'd0;
      w_inexact = 1'b0;
    end
  end

  // Control FSM with capture, normalization and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_prod    <= '0;
      r_sign    <= 1'b0;
      r_mode    <= 2'b00;
      r_m       <= '0;
      r_g       <= 1'b0;
      r_s       <= 1'b0;
      r_e       <= 1'b0;
      r_z       <= 1'b0;
      r_sgf     <= '0;
      r_exp_adj <= 2'd0;
      r_inexact <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_prod  <= product_i;
            r_sign  <= sign_i;
            r_mode  <= r_mode_i;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_m     <= w_m;
          r_g     <= w_g;
          r_s     <= w_s;
          r_e     <= w_e;
          r_z     <= w_z;
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_sgf     <= w_sgf;
          r_exp_adj <= w_exp_adj;
          r_inexact <= w_inexact;
          r_zero    <= r_z;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (ack_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o   = (r_state == S_IDLE);
  assign done_o    = (r_state == S_DONE);
  assign sgf_o     = r_sgf;
  assign exp_adj_o = r_exp_adj;
  assign inexact_o = r_inexact;
  assign zero_o    = r_zero;

endmodule

// File: tb/tb_sgf_round_norm.sv
// tb_sgf_round_norm: directed bench for sgf_round_norm with SW=24.
// Expected results are queued when an operation is launched and popped when
// done_o is observed.
module tb_sgf_round_norm;

  localparam int SW = 24;

  logic            clk;
  logic            rst;
  logic            start_i;
  logic            ack_i;
  logic [2*SW-1:0] product_i;
  logic            sign_i;
  logic [1:0]      r_mode_i;
  logic            ready_o;
  logic            done_o;
  logic [SW-1:0]   sgf_o;
  logic [1:0]      exp_adj_o;
  logic            inexact_o;
  logic            zero_o;

  typedef struct packed {
    logic [SW-1:0] sgf;
    logic [1:0]    adj;
    logic          inx;
    logic          zero;
  } expect_t;

  expect_t sbQueue[$];

  int nCompared;
  int nMismatched;
  int cycleCount;
  int startEdge;

  sgf_round_norm #(.SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .ack_i     (ack_i),
    .product_i (product_i),
    .sign_i    (sign_i),
    .r_mode_i  (r_mode_i),
    .ready_o   (ready_o),
    .done_o    (done_o),
    .sgf_o     (sgf_o),
    .exp_adj_o (exp_adj_o),
    .inexact_o (inexact_o),
    .zero_o    (zero_o)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to measure latency from the launch cycle
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] expv);
    nCompared++;
    assert (obs === expv)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic waitReady(input string tag);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ready_o !== 1'b1) check({tag, "/ready_timeout"}, 48'(ready_o), 48'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic [2*SW-1:0] p, input logic s,
                               input logic [1:0] mode, input logic [SW-1:0] eSgf,
                               input logic [1:0] eAdj, input logic eInx, input logic eZero);
    expect_t e;
    waitReady(tag);
    startEdge = cycleCount;
    start_i   = 1'b1;
    product_i = p;
    sign_i    = s;
    r_mode_i  = mode;
    e.sgf  = eSgf;
    e.adj  = eAdj;
    e.inx  = eInx;
    e.zero = eZero;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    product_i = '0;
    sign_i    = 1'b0;
    r_mode_i  = 2'b00;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_o !== 1'b1) check({tag, "/done_timeout"}, 48'(done_o), 48'd1);
  endtask

  task automatic checkOutput(input string tag);
    expect_t e;
    waitDone(tag);
    check({tag, "/latency"}, 48'(cycleCount - startEdge), 48'd3);
    if (sbQueue.size() == 0) begin
      check({tag, "/sb_empty"}, 48'd0, 48'd1);
    end else begin
      e = sbQueue.pop_front();
      check({tag, "/ready_in_done"}, 48'(ready_o), 48'd0);
      check({tag, "/sgf"}, 48'(sgf_o), 48'(e.sgf));
      check({tag, "/exp_adj"}, 48'(exp_adj_o), 48'(e.adj));
      check({tag, "/inexact"}, 48'(inexact_o), 48'(e.inx));
      check({tag, "/zero"}, 48'(zero_o), 48'(e.zero));
    end
  endtask

  task automatic doAck(input string tag, input logic [SW-1:0] heldSgf);
    ack_i = 1'b1;
    @(posedge clk);
    #1;
    ack_i = 1'b0;
    check({tag, "/ready_after_ack"}, 48'(ready_o), 48'd1);
    check({tag, "/done_after_ack"}, 48'(done_o), 48'd0);
    check({tag, "/sgf_held_idle"}, 48'(sgf_o), 48'(heldSgf));
  endtask

  // Directed sequence
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    cycleCount  = 0;
    rst         = 1'b1;
    start_i     = 1'b1;
    ack_i       = 1'b0;
    product_i   = 48'hFFFFFF800000;
    sign_i      = 1'b1;
    r_mode_i    = 2'b10;

    // Reset held two cycles with start_i asserted
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    start_i   = 1'b0;
    product_i = '0;
    sign_i    = 1'b0;
    r_mode_i  = 2'b00;
    check("reset/ready", 48'(ready_o), 48'd1);
    check("reset/done", 48'(done_o), 48'd0);
    check("reset/sgf", 48'(sgf_o), 48'd0);
    check("reset/exp_adj", 48'(exp_adj_o), 48'd0);
    check("reset/inexact", 48'(inexact_o), 48'd0);
    check("reset/zero", 48'(zero_o), 48'd0);
    @(posedge clk);
    #1;
    check("reset/still_idle", 48'(ready_o), 48'd1);

    // Exact 1.0 x 1.0
    applyStimulus("exact", 48'h400000000000, 1'b0, 2'b00, 24'h800000, 2'd0, 1'b0, 1'b0);
    checkOutput("exact");
    doAck("exact", 24'h800000);

    // Tie cases: m=0x800000, g=1, s=0
    applyStimulus("tie_rne", 48'h400000400000, 1'b0, 2'b00, 24'h800000, 2'd0, 1'b1, 1'b0);
    checkOutput("tie_rne");
    doAck("tie_rne", 24'h800000);
    applyStimulus("tie_pinf_pos", 48'h400000400000, 1'b0, 2'b10, 24'h800001, 2'd0, 1'b1, 1'b0);
    checkOutput("tie_pinf_pos");
    doAck("tie_pinf_pos", 24'h800001);
    applyStimulus("tie_ninf_pos", 48'h400000400000, 1'b0, 2'b11, 24'h800000, 2'd0, 1'b1, 1'b0);
    checkOutput("tie_ninf_pos");
    doAck("tie_ninf_pos", 24'h800000);
    applyStimulus("tie_ninf_neg", 48'h400000400000, 1'b1, 2'b11, 24'h800001, 2'd0, 1'b1, 1'b0);
    checkOutput("tie_ninf_neg");
    doAck("tie_ninf_neg", 24'h800001);
    applyStimulus("tie_rz", 48'h400000400000, 1'b1, 2'b01, 24'h800000, 2'd0, 1'b1, 1'b0);
    checkOutput("tie_rz");
    doAck("tie_rz", 24'h800000);

    // Odd tie rounds up to even under RNE: m=0x800001, g=1, s=0
    applyStimulus("tie_odd_rne", 48'h400000C00000, 1'b0, 2'b00, 24'h800002, 2'd0, 1'b1, 1'b0);
    checkOutput("tie_odd_rne");
    doAck("tie_odd_rne", 24'h800002);

    // Sticky only: below half, RNE keeps, +inf on positive bumps
    applyStimulus("sticky_rne", 48'h400000000001, 1'b0, 2'b00, 24'h800000, 2'd0, 1'b1, 1'b0);
    checkOutput("sticky_rne");
    doAck("sticky_rne", 24'h800000);
    applyStimulus("sticky_pinf", 48'h400000000001, 1'b0, 2'b10, 24'h800001, 2'd0, 1'b1, 1'b0);
    checkOutput("sticky_pinf");
    doAck("sticky_pinf", 24'h800001);

    // Top bit set, exact: exponent increment of 1
    applyStimulus("top_exact", 48'h800000000000, 1'b0, 2'b00, 24'h800000, 2'd1, 1'b0, 1'b0);
    checkOutput("top_exact");
    doAck("top_exact", 24'h800000);

    // Rounding carry-out and the same product truncated
    applyStimulus("carry_rne", 48'hFFFFFF800000, 1'b0, 2'b00, 24'h800000, 2'd2, 1'b1, 1'b0);
    checkOutput("carry_rne");
    doAck("carry_rne", 24'h800000);
    applyStimulus("carry_rz", 48'hFFFFFF800000, 1'b0, 2'b01, 24'hFFFFFF, 2'd1, 1'b1, 1'b0);
    checkOutput("carry_rz");

    // Zero product with a long DONE hold and ignored start pulses
    doAck("carry_rz", 24'hFFFFFF);
    applyStimulus("zero", 48'h000000000000, 1'b0, 2'b01, 24'h000000, 2'd0, 1'b0, 1'b1);
    checkOutput("zero");
    for (int i = 0; i < 5; i++) begin
      start_i   = i[0];
      product_i = 48'h800000000000;
      @(posedge clk);
      #1;
      check("hold/done", 48'(done_o), 48'd1);
      check("hold/ready", 48'(ready_o), 48'd0);
      check("hold/sgf", 48'(sgf_o), 48'd0);
      check("hold/zero", 48'(zero_o), 48'd1);
      check("hold/exp_adj", 48'(exp_adj_o), 48'd0);
    end
    start_i   = 1'b0;
    product_i = '0;
    doAck("zero", 24'h000000);

    // Reset asserted during ROUND aborts the operation
    waitReady("abort");
    start_i   = 1'b1;
    product_i = 48'hFFFFFF800000;
    r_mode_i  = 2'b00;
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    product_i = '0;
    check("abort/norm_done", 48'(done_o), 48'd0);
    @(posedge clk);
    #1;
    check("abort/round_done", 48'(done_o), 48'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort/done", 48'(done_o), 48'd0);
    check("abort/ready", 48'(ready_o), 48'd1);
    check("abort/sgf", 48'(sgf_o), 48'd0);
    check("abort/exp_adj", 48'(exp_adj_o), 48'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("abort/no_done", 48'(done_o), 48'd0);
    end

    // Normal operation after the abort
    applyStimulus("post_abort", 48'h400000000000, 1'b0, 2'b00, 24'h800000, 2'd0, 1'b0, 1'b0);
    checkOutput("post_abort");
    doAck("post_abort", 24'h800000);

    check("sb_drained", 48'(sbQueue.size()), 48'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
